// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, opcodes and the 1149.1 next-state function.
package jtag_tap_pkg;

  localparam int IR_LEN_DEF = 4;

  localparam logic [3:0] OP_IDCODE  = 4'b0010;
  localparam logic [3:0] OP_DEBUG   = 4'b1000;
  localparam logic [3:0] OP_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronizer for a bundle of pins, with rise/fall detection on bit 0.
// Bit 0 carries the clock-like signal; the remaining bits are only synchronized
// so they arrive with exactly the same latency as the detected edge.
module jtag_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] meta_p0;
  logic [W-1:0] sync_p1;
  logic         prev_p2;

  // metastability flop -> synchronized flop -> previous value of bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1[0];
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1[0] & ~prev_p2;
  assign fall = ~sync_p1[0] & prev_p2;

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP controller running entirely in the wb_clk_i domain; TCK is oversampled
// and each detected TCK edge is treated as a one-cycle enable.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter int          IR_LEN       = IR_LEN_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        tck_pad_i,
  input  logic        tms_pad_i,
  input  logic        tdi_pad_i,
  output logic        tdo_pad_o,
  output logic        tdo_padoe_o,
  input  logic [31:0] user_capture_i,
  output logic [31:0] user_dr_o,
  output logic        user_update_o,
  output logic        test_logic_reset_o
);

  logic [2:0]        sync_bus;
  logic              tck_rise;
  logic              tck_fall;
  logic              tms_s;
  logic              tdi_s;
  tap_state_t        state;
  tap_state_t        state_nxt;
  logic [IR_LEN-1:0] ir;
  logic [IR_LEN-1:0] ir_sr;
  logic [31:0]       dr_sr;
  logic              bp_sr;
  logic              sel_idcode;
  logic              sel_debug;
  logic              dr_lsb;

  jtag_sync_edge #(.W(3)) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    ({tdi_pad_i, tms_pad_i, tck_pad_i}),
    .q    (sync_bus),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  assign tms_s = sync_bus[1];
  assign tdi_s = sync_bus[2];

  // instruction decode and selected-register serial output; unknown opcodes fall to bypass
  always_comb begin
    state_nxt  = tap_next(state, tms_s);
    sel_idcode = (ir == IR_LEN'(OP_IDCODE));
    sel_debug  = (ir == IR_LEN'(OP_DEBUG));
    dr_lsb     = (sel_idcode || sel_debug) ? dr_sr[0] : bp_sr;
  end

  // TAP state machine: capture/shift on TCK rise, TDO drive and update on TCK fall
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state              <= TLR;
      ir                 <= IR_LEN'(OP_IDCODE);
      ir_sr              <= '0;
      dr_sr              <= '0;
      bp_sr              <= 1'b0;
      tdo_pad_o          <= 1'b0;
      tdo_padoe_o        <= 1'b0;
      user_dr_o          <= '0;
      user_update_o      <= 1'b0;
      test_logic_reset_o <= 1'b1;
    end else begin
      user_update_o <= 1'b0;
      if (tck_rise) begin
        state              <= state_nxt;
        test_logic_reset_o <= (state_nxt == TLR);
        if (state_nxt == TLR) begin
          ir <= IR_LEN'(OP_IDCODE);
        end
        case (state)
          CAP_IR:   ir_sr <= IR_LEN'(IR_CAPTURE);
          SHIFT_IR: ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
          CAP_DR: begin
            if (sel_idcode)     dr_sr <= IDCODE_VALUE;
            else if (sel_debug) dr_sr <= user_capture_i;
            else                bp_sr <= 1'b0;
          end
          SHIFT_DR: begin
            if (sel_idcode || sel_debug) dr_sr <= {tdi_s, dr_sr[31:1]};
            else                         bp_sr <= tdi_s;
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        tdo_pad_o   <= (state == SHIFT_IR) ? ir_sr[0] : dr_lsb;
        tdo_padoe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
        if (state == UPD_IR) begin
          ir <= ir_sr;
        end
        if (state == UPD_DR && sel_debug) begin
          user_dr_o     <= dr_sr;
          user_update_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: TCK is driven with 8-cycle half periods.
module tb_jtag_tap_sampled;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        tdo_oe;
  logic [31:0] user_capture = 32'h12345678;
  logic [31:0] user_dr;
  logic        user_update;
  logic        tlr;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int run_len = 0;
  int max_run = 0;

  logic tdo_prev;
  logic oe_prev;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .wb_clk_i           (clk),
    .wb_rst_i           (rst),
    .tck_pad_i          (tck),
    .tms_pad_i          (tms),
    .tdi_pad_i          (tdi),
    .tdo_pad_o          (tdo),
    .tdo_padoe_o        (tdo_oe),
    .user_capture_i     (user_capture),
    .user_dr_o          (user_dr),
    .user_update_o      (user_update),
    .test_logic_reset_o (tlr)
  );

  // count update-pulse cycles and the longest contiguous run
  always @(negedge clk) begin
    if (user_update) begin
      pulse_cnt = pulse_cnt + 1;
      run_len   = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one TCK period; records TDO/OE as left by the previous falling edge
  task automatic tck_step(input logic tms_v, input logic tdi_v);
    tdo_prev = tdo;
    oe_prev  = tdo_oe;
    tms = tms_v;
    tdi = tdi_v;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (8) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift(input int n, input logic [31:0] din,
                       output logic [31:0] dout, output logic all_oe);
    dout   = '0;
    all_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_step(i == n - 1, din[i]);
      dout[i] = tdo_prev;
      all_oe  = all_oe & oe_prev;
    end
  endtask

  task automatic to_shift_dr();
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  task automatic update_to_rti();
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [31:0] cap);
    logic oe;
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    shift(4, {28'h0, op}, cap, oe);
    update_to_rti();
  endtask

  initial begin
    logic [31:0] d;
    logic        oe;
    int          p0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tdo", {31'h0, tdo}, 32'h0);
    chk("rst_oe", {31'h0, tdo_oe}, 32'h0);
    chk("rst_user_dr", user_dr, 32'h0);
    chk("rst_update", {31'h0, user_update}, 32'h0);
    chk("rst_tlr", {31'h0, tlr}, 32'h1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // IDCODE read straight out of reset
    tck_step(1'b0, 1'b0);
    chk("rti_tlr", {31'h0, tlr}, 32'h0);
    to_shift_dr();
    chk("capdr_oe", {31'h0, oe_prev}, 32'h0);
    shift(32, 32'h0, d, oe);
    chk("idcode", d, 32'h149511C3);
    chk("idcode_oe", {31'h0, oe}, 32'h1);
    update_to_rti();
    chk("exit_oe", {31'h0, oe_prev}, 32'h0);
    chk("idcode_no_pulse", pulse_cnt, 32'h0);

    // IR capture pattern 1,0,1,0 while loading DEBUG
    load_ir(4'b1000, d);
    chk("ir_capture", d, 32'h5);

    // DEBUG data register round trip
    to_shift_dr();
    shift(32, 32'hDEADBEEF, d, oe);
    chk("debug_capture", d, 32'h12345678);
    p0 = pulse_cnt;
    update_to_rti();
    chk("debug_user_dr", user_dr, 32'hDEADBEEF);
    chk("debug_pulse_cnt", pulse_cnt - p0, 32'h1);
    chk("debug_pulse_width", max_run, 32'h1);

    // BYPASS: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
    load_ir(4'b1111, d);
    to_shift_dr();
    shift(5, 32'h0D, d, oe);
    chk("bypass_f", d, 32'h1A);
    p0 = pulse_cnt;
    update_to_rti();
    chk("bypass_user_dr", user_dr, 32'hDEADBEEF);
    chk("bypass_no_pulse", pulse_cnt - p0, 32'h0);

    // unknown opcode behaves as BYPASS
    load_ir(4'b0110, d);
    to_shift_dr();
    shift(5, 32'h0D, d, oe);
    chk("bypass_0110", d, 32'h1A);
    update_to_rti();

    // five TMS=1 rises from Shift-DR reach Test-Logic-Reset
    to_shift_dr();
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) tck_step(1'b1, 1'b0);
    chk("tlr_after4", {31'h0, tlr}, 32'h0);
    tck_step(1'b1, 1'b0);
    chk("tlr_after5", {31'h0, tlr}, 32'h1);
    chk("tlr_no_pulse", pulse_cnt - p0, 32'h0);
    tck_step(1'b0, 1'b0);
    to_shift_dr();
    shift(32, 32'h0, d, oe);
    chk("tlr_ir_idcode", d, 32'h149511C3);
    update_to_rti();

    // reset in the middle of a DEBUG shift
    load_ir(4'b1000, d);
    to_shift_dr();
    for (int i = 0; i < 17; i++) tck_step(1'b0, 1'b1);
    chk("midshift_oe", {31'h0, tdo_oe}, 32'h1);
    p0 = pulse_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_tdo", {31'h0, tdo}, 32'h0);
    chk("midrst_oe", {31'h0, tdo_oe}, 32'h0);
    chk("midrst_user_dr", user_dr, 32'h0);
    chk("midrst_update", {31'h0, user_update}, 32'h0);
    chk("midrst_tlr", {31'h0, tlr}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_pulse", pulse_cnt - p0, 32'h0);
    tck_step(1'b0, 1'b0);
    to_shift_dr();
    shift(32, 32'h0, d, oe);
    chk("post_rst_idcode", d, 32'h149511C3);
    update_to_rti();
    chk("post_rst_user_dr", user_dr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
